// File: rtl/interconnect_cfg_pkg.sv
// rtl/interconnect_cfg_pkg.sv - shared constants and state type for the interconnect config loader
package interconnect_cfg_pkg;

    localparam int SEL_W = 6;
    localparam int SEL_MAX = 39;
    localparam logic [7:0] SYNC_WORD = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        LOAD,
        CHECK,
        DONE,
        ERROR
    } cfg_state_t;

    function automatic logic sel_illegal(input logic [SEL_W-1:0] sel);
        return sel > SEL_W'(SEL_MAX);
    endfunction

endpackage

// File: rtl/cfg_sync_detect.sv
// rtl/cfg_sync_detect.sv - 8-bit serial sync word detector with clear
module cfg_sync_detect
    import interconnect_cfg_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic shift_en,
    input  logic bit_in,
    output logic match
);

    logic [7:0] shifter;
    logic [7:0] shifter_next;

    // First-received bit ends up at the MSB; match looks at the value being loaded this edge
    assign shifter_next = {shifter[6:0], bit_in};
    assign match = shift_en && (shifter_next == SYNC_WORD);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shifter <= '0;
        end else if (shift_en) begin
            shifter <= shifter_next;
        end
    end

endmodule

// File: rtl/interconnect_cfg_loader.sv
// rtl/interconnect_cfg_loader.sv - framed serial loader for per-CLB interconnect mux selects
module interconnect_cfg_loader
    import interconnect_cfg_pkg::*;
#(
    parameter int N_INP = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_start,
    input  logic                     cfg_valid,
    input  logic                     cfg_data,
    output logic [N_INP*SEL_W-1:0]   interconnect_switch,
    output logic                     prgm_b,
    output logic                     CLB_prgm_b,
    output logic                     cfg_busy,
    output logic                     cfg_err
);

    localparam int PAY_W = N_INP * SEL_W;
    localparam int CNT_W = $clog2(PAY_W + 2);
    localparam int FC_W  = $clog2(SEL_W);

    cfg_state_t        state;
    logic [PAY_W-1:0]  shadow;
    logic [CNT_W-1:0]  bit_cnt;
    logic [FC_W-1:0]   fld_cnt;
    logic [SEL_W-2:0]  fld_acc;
    logic              parity;
    logic              illegal;
    logic              sync_shift;
    logic              sync_match;
    logic [SEL_W-1:0]  fld_next;

    assign fld_next   = {fld_acc, cfg_data};
    assign sync_shift = (state == SYNC) && cfg_valid && !cfg_start;

    cfg_sync_detect u_sync_detect (
        .clk      (clk),
        .rst      (rst),
        .clear    (cfg_start),
        .shift_en (sync_shift),
        .bit_in   (cfg_data),
        .match    (sync_match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            interconnect_switch <= '0;
            prgm_b              <= 1'b0;
            CLB_prgm_b          <= 1'b1;
            cfg_busy            <= 1'b0;
            cfg_err             <= 1'b0;
            shadow              <= '0;
            bit_cnt             <= '0;
            fld_cnt             <= '0;
            fld_acc             <= '0;
            parity              <= 1'b0;
            illegal             <= 1'b0;
        end else if (cfg_start) begin
            // Abort whatever is in flight; the committed selects stay on the bus
            state      <= SYNC;
            prgm_b     <= 1'b0;
            CLB_prgm_b <= 1'b1;
            cfg_busy   <= 1'b1;
            cfg_err    <= 1'b0;
            shadow     <= '0;
            bit_cnt    <= '0;
            fld_cnt    <= '0;
            fld_acc    <= '0;
            parity     <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            case (state)
                IDLE: ;
                SYNC: begin
                    if (sync_match) begin
                        state   <= LOAD;
                        shadow  <= '0;
                        bit_cnt <= '0;
                        fld_cnt <= '0;
                        fld_acc <= '0;
                        parity  <= 1'b0;
                        illegal <= 1'b0;
                    end
                end
                LOAD: begin
                    if (cfg_valid) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        parity  <= parity ^ cfg_data;
                        if (bit_cnt == CNT_W'(PAY_W)) begin
                            state <= CHECK;
                        end else if (fld_cnt == FC_W'(SEL_W - 1)) begin
                            // Completed fields enter at the top, so field 0 ends up in the low slot
                            shadow  <= {fld_next, shadow[PAY_W-1:SEL_W]};
                            fld_acc <= '0;
                            fld_cnt <= '0;
                            if (sel_illegal(fld_next)) begin
                                illegal <= 1'b1;
                            end
                        end else begin
                            fld_acc <= fld_next[SEL_W-2:0];
                            fld_cnt <= fld_cnt + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    cfg_busy <= 1'b0;
                    if (!parity && !illegal) begin
                        interconnect_switch <= shadow;
                        prgm_b              <= 1'b1;
                        CLB_prgm_b          <= 1'b0;
                        state               <= DONE;
                    end else begin
                        cfg_err <= 1'b1;
                        state   <= ERROR;
                    end
                end
                DONE: ;
                ERROR: ;
                default: begin
                    state    <= IDLE;
                    cfg_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interconnect_cfg_loader.sv
// tb/tb_interconnect_cfg_loader.sv - scoreboard bench for interconnect_cfg_loader
module tb_interconnect_cfg_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_data = 1'b0;
    logic [23:0] interconnect_switch;
    logic        prgm_b;
    logic        CLB_prgm_b;
    logic        cfg_busy;
    logic        cfg_err;

    typedef struct packed {
        logic [23:0] sw;
        logic        pb;
        logic        clb;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    bit   stall_en = 1'b0;

    interconnect_cfg_loader #(.N_INP(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .cfg_start           (cfg_start),
        .cfg_valid           (cfg_valid),
        .cfg_data            (cfg_data),
        .interconnect_switch (interconnect_switch),
        .prgm_b              (prgm_b),
        .CLB_prgm_b          (CLB_prgm_b),
        .cfg_busy            (cfg_busy),
        .cfg_err             (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Monitor: a falling cfg_busy marks the end of a frame (or a reset out of one)
    initial begin
        logic prev_busy;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_busy === 1'b1 && cfg_busy === 1'b0) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_end: busy fell with nothing expected, switch=%0h", interconnect_switch);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_switch", interconnect_switch, e.sw);
                    check("sb_prgm_b", prgm_b, e.pb);
                    check("sb_clb_prgm_b", CLB_prgm_b, e.clb);
                    check("sb_cfg_err", cfg_err, e.err);
                end
            end
            prev_busy = cfg_busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_result(input logic [23:0] sw, input logic pb, input logic clb, input logic err);
        exp_q.push_back('{sw: sw, pb: pb, clb: clb, err: err});
    endtask

    task automatic send_bit(input logic b);
        if (stall_en) begin
            repeat ($urandom_range(0, 2)) begin
                cfg_valid = 1'b0;
                cfg_data  = ~b;
                tick();
            end
        end
        cfg_valid = 1'b1;
        cfg_data  = b;
        tick();
        cfg_valid = 1'b0;
        cfg_data  = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send_frame(input logic [5:0] f0, input logic [5:0] f1, input logic [5:0] f2,
                              input logic [5:0] f3, input logic par, input logic chk);
        send_bits(32'hA5, 8);
        send_bits({26'd0, f0}, 6);
        send_bits({26'd0, f1}, 6);
        send_bits({26'd0, f2}, 6);
        send_bits({26'd0, f3}, 6);
        send_bit(par);
        if (chk) begin
            check("busy_in_check", cfg_busy, 1);
            check("prgm_b_in_check", prgm_b, 0);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        total_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else begin
            $display("FAIL %s: %0d results still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_switch", interconnect_switch, 0);
        check("rst_prgm_b", prgm_b, 0);
        check("rst_clb_prgm_b", CLB_prgm_b, 1);
        check("rst_busy", cfg_busy, 0);
        check("rst_err", cfg_err, 0);

        // Fields 1,15,39,0 carry nine ones, so even parity needs parity bit 1
        start();
        expect_result(24'h0273C1, 1'b1, 1'b0, 1'b0);
        send_frame(6'd1, 6'd15, 6'd39, 6'd0, 1'b1, 1'b1);
        drain("good_frame");

        rst = 1'b1;
        tick();
        rst = 1'b0;
        start();
        expect_result(24'h0, 1'b0, 1'b1, 1'b1);
        send_frame(6'd1, 6'd15, 6'd39, 6'd0, 1'b0, 1'b1);
        drain("bad_parity");

        start();
        check("start_clears_err", cfg_err, 0);
        check("start_sets_busy", cfg_busy, 1);
        expect_result(24'h0, 1'b0, 1'b1, 1'b1);
        send_frame(6'd1, 6'd15, 6'd40, 6'd0, 1'b1, 1'b1);
        drain("illegal_field");

        // Preamble 1010010101 holds A5 in its first 8 bits; loaded fields become 26,20,4,62
        stall_en = 1'b1;
        start();
        expect_result(24'h0, 1'b0, 1'b1, 1'b1);
        send_bits(32'h295, 10);
        send_frame(6'd1, 6'd15, 6'd39, 6'd0, 1'b1, 1'b0);
        drain("early_sync");

        // Preamble 1010010010 has no A5 window, so the real sync word is found
        start();
        expect_result(24'h0273C1, 1'b1, 1'b0, 1'b0);
        send_bits(32'h292, 10);
        send_frame(6'd1, 6'd15, 6'd39, 6'd0, 1'b1, 1'b1);
        drain("stalled_frame");
        stall_en = 1'b0;

        start();
        send_bits(32'hA5, 8);
        send_bits(32'h145, 12);
        check("abort_switch_held", interconnect_switch, 24'h0273C1);
        check("abort_prgm_b", prgm_b, 0);
        check("abort_clb_prgm_b", CLB_prgm_b, 1);
        start();
        check("restart_prgm_b", prgm_b, 0);
        check("restart_switch_held", interconnect_switch, 24'h0273C1);
        expect_result(24'h145145, 1'b1, 1'b0, 1'b0);
        send_frame(6'd5, 6'd5, 6'd5, 6'd5, 1'b0, 1'b1);
        drain("fives_frame");

        start();
        send_bits(32'hA5, 8);
        send_bits(32'h5, 7);
        check("load_busy", cfg_busy, 1);
        expect_result(24'h0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_switch", interconnect_switch, 0);
        check("midrst_busy", cfg_busy, 0);
        drain("mid_load_reset");

        // A bit offered together with cfg_start must be dropped, else 1+0100101 would sync early
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = 1'b0;
        expect_result(24'h0273C1, 1'b1, 1'b0, 1'b0);
        send_bits(32'h25, 7);
        send_frame(6'd1, 6'd15, 6'd39, 6'd0, 1'b1, 1'b1);
        drain("post_reset_frame");

        repeat (3) tick();
        check("done_holds_switch", interconnect_switch, 24'h0273C1);
        check("done_busy", cfg_busy, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
